seq_det_ctrl: RTL and testbench

- Programmable serial pattern-detector controller that owns configuration, arming, match counting and completion for a Mealy-style bit-stream detector.
- Generalises the fixed "11" detector to a loadable pattern of up to PAT_W bits.
- Sits between a host/config master and the serial input `x`.
- Drives a match pulse `y` plus count/status outputs.

---
 rtl/seq_det_pkg.sv | 20 ++
 rtl/seq_det_ctrl_if.sv | 38 +++
 rtl/pat_match_core.sv | 71 +++++++
 rtl/seq_det_ctrl.sv | 160 ++++++++++++++++
 tb/tb_seq_det_ctrl.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared types and default widths for the programmable
// serial pattern detector (seq_det_ctrl, pat_match_core, seq_det_ctrl_if).
package seq_det_pkg;

  // Default geometry: maximum pattern length, length-field width, counter width.
  localparam int DEF_PAT_W = 8;
  localparam int DEF_LEN_W = 4;
  localparam int DEF_CNT_W = 8;

  // Saturation value of the match counter at the default counter width.
  localparam int CNT_MAX = (2 ** DEF_CNT_W) - 1;

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/seq_det_ctrl_if.sv
// seq_det_ctrl_if: configuration / control / serial-data bundle between a
// host (master) and the seq_det_ctrl detector (slave).
interface seq_det_ctrl_if
  import seq_det_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W,
  parameter int LEN_W = DEF_LEN_W,
  parameter int CNT_W = DEF_CNT_W
);

  logic             cfg_valid;
  logic             cfg_ready;
  logic [PAT_W-1:0] cfg_pattern;
  logic [LEN_W-1:0] cfg_len;
  logic [CNT_W-1:0] cfg_target;
  logic             cfg_overlap;
  logic             start;
  logic             abort;
  logic             x;
  logic             x_valid;
  logic             y;
  logic [CNT_W-1:0] match_cnt;
  logic             busy;
  logic             done;

  modport master (
    output cfg_valid, cfg_pattern, cfg_len, cfg_target, cfg_overlap,
    output start, abort, x, x_valid,
    input  cfg_ready, y, match_cnt, busy, done
  );

  modport slave (
    input  cfg_valid, cfg_pattern, cfg_len, cfg_target, cfg_overlap,
    input  start, abort, x, x_valid,
    output cfg_ready, y, match_cnt, busy, done
  );

endinterface

// File: rtl/pat_match_core.sv
// pat_match_core: history shift register plus fill counter for the serial
// detector, and the combinational "current bit completes the pattern" term.
// The newest bit is i_x (window bit 0); older bits sit in r_hist.
module pat_match_core #(
  parameter int PAT_W = 8,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_x,
  input  logic             i_x_valid,
  input  logic             i_clr,
  input  logic [LEN_W-1:0] i_len,
  input  logic [PAT_W-1:0] i_pattern,
  output logic             o_match
);

  logic [PAT_W-2:0] r_hist;
  logic [LEN_W-1:0] r_fill;
  logic [PAT_W-1:0] w_window;
  logic [PAT_W-1:0] w_mask;
  logic             w_fill_ok;

  assign w_window = {r_hist, i_x};

  // Enough history exists once fill + current bit covers the pattern length.
  assign w_fill_ok = ({1'b0, r_fill} + {{LEN_W{1'b0}}, 1'b1}) >= {1'b0, i_len};

  // Mask selecting the low i_len bits of the window and pattern.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < PAT_W; i++) begin
      if (LEN_W'(i) < i_len) begin
        w_mask[i] = 1'b1;
      end else begin
        w_mask[i] = 1'b0;
      end
    end
  end

  // Match term: qualified bit, sufficient history, masked window equals pattern.
  always_comb begin
    if (i_x_valid && w_fill_ok) begin
      o_match = ((w_window & w_mask) == (i_pattern & w_mask));
    end else begin
      o_match = 1'b0;
    end
  end

  // History shifts on qualified bits; fill counts them up to PAT_W; clear wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (i_clr) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (i_x_valid) begin
      r_hist <= w_window[PAT_W-2:0];
      if (r_fill != LEN_W'(PAT_W)) begin
        r_fill <= r_fill + {{(LEN_W-1){1'b0}}, 1'b1};
      end else begin
        r_fill <= r_fill;
      end
    end else begin
      r_hist <= r_hist;
      r_fill <= r_fill;
    end
  end

endmodule

// File: rtl/seq_det_ctrl.sv
// seq_det_ctrl: controller for a programmable serial pattern detector.
// Owns the config registers, IDLE/ARMED/DONE sequencing, match counting and
// the completion pulse. Optional macro SEQ_DET_MOORE_OUT_EN registers y
// (one-cycle latency); otherwise y is the combinational Mealy match.
module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W,
  parameter int LEN_W = DEF_LEN_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic          clk,
  input  logic          rst,
  seq_det_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] L_CNT_MAX = {CNT_W{1'b1}};

  state_e           r_state;
  logic [PAT_W-1:0] r_pattern;
  logic [LEN_W-1:0] r_len;
  logic [CNT_W-1:0] r_target;
  logic             r_overlap;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic             r_cfg_ready;
`ifdef SEQ_DET_MOORE_OUT_EN
  logic             r_y;
`endif

  logic             w_idle;
  logic             w_armed;
  logic             w_core_valid;
  logic             w_core_clr;
  logic             w_match;
  logic             w_y;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_hit_target;
  logic [LEN_W-1:0] w_len_clamped;

  assign w_idle       = (r_state == ST_IDLE);
  assign w_armed      = (r_state == ST_ARMED);
  assign w_core_valid = w_armed & bus.x_valid;
  assign w_y          = w_armed & w_match;
  // Arming restarts history; a non-overlapping match discards the used bits.
  assign w_core_clr   = (w_idle & bus.start) | (w_y & ~r_overlap);
  assign w_cnt_inc    = (r_cnt == L_CNT_MAX) ? r_cnt : (r_cnt + {{(CNT_W-1){1'b0}}, 1'b1});
  assign w_hit_target = (r_target != '0) && (w_cnt_inc == r_target);

  // Length 0 behaves as 1; lengths beyond the history depth clamp to PAT_W.
  always_comb begin
    if (bus.cfg_len == '0) begin
      w_len_clamped = {{(LEN_W-1){1'b0}}, 1'b1};
    end else if (bus.cfg_len > LEN_W'(PAT_W)) begin
      w_len_clamped = LEN_W'(PAT_W);
    end else begin
      w_len_clamped = bus.cfg_len;
    end
  end

  pat_match_core #(
    .PAT_W (PAT_W),
    .LEN_W (LEN_W)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .i_x       (bus.x),
    .i_x_valid (w_core_valid),
    .i_clr     (w_core_clr),
    .i_len     (r_len),
    .i_pattern (r_pattern),
    .o_match   (w_match)
  );

  // Controller FSM: config capture, arming, counting, abort and completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_pattern   <= '0;
      r_len       <= {{(LEN_W-1){1'b0}}, 1'b1};
      r_target    <= '0;
      r_overlap   <= 1'b1;
      r_cnt       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_cfg_ready <= 1'b1;
`ifdef SEQ_DET_MOORE_OUT_EN
      r_y         <= 1'b0;
`endif
    end else begin
`ifdef SEQ_DET_MOORE_OUT_EN
      r_y <= w_y;
`endif
      case (r_state)
        ST_IDLE: begin
          // Config lands on the same edge as start, so it applies to this arm.
          if (bus.cfg_valid) begin
            r_pattern <= bus.cfg_pattern;
            r_len     <= w_len_clamped;
            r_target  <= bus.cfg_target;
            r_overlap <= bus.cfg_overlap;
          end else begin
            r_pattern <= r_pattern;
          end
          if (bus.start) begin
            r_state     <= ST_ARMED;
            r_cnt       <= '0;
            r_busy      <= 1'b1;
            r_cfg_ready <= 1'b0;
            r_done      <= 1'b0;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_ARMED: begin
          if (w_y) begin
            r_cnt <= w_cnt_inc;
          end else begin
            r_cnt <= r_cnt;
          end
          // Abort takes priority over reaching the target.
          if (bus.abort) begin
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_cfg_ready <= 1'b1;
          end else if (w_y && w_hit_target) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_state <= ST_ARMED;
          end
        end
        ST_DONE: begin
          r_state     <= ST_IDLE;
          r_done      <= 1'b0;
          r_cfg_ready <= 1'b1;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_busy      <= 1'b0;
          r_done      <= 1'b0;
          r_cfg_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.cfg_ready = r_cfg_ready;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.match_cnt = r_cnt;
`ifdef SEQ_DET_MOORE_OUT_EN
  assign bus.y         = r_y;
`else
  assign bus.y         = w_y;
`endif

endmodule

// File: tb/tb_seq_det_ctrl.sv
// tb_seq_det_ctrl: directed plus randomized bench for seq_det_ctrl with a
// queue-based reference model of the detector. Honors SEQ_DET_MOORE_OUT_EN.
module tb_seq_det_ctrl;

  localparam int PAT_W = 8;
  localparam int LEN_W = 4;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  seq_det_ctrl_if #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) bus ();

  seq_det_ctrl #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: mode 0 = idle, 1 = armed, 2 = done.
  int         m_mode;
  logic [7:0] m_pat;
  int         m_len;
  int         m_tgt;
  bit         m_ovl;
  int         m_cnt;
  bit         m_hist[$];
  bit         m_ypend;

  logic [15:0] ymask;
  logic [15:0] dmask;
  int          tidx;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode  = 0;
    m_pat   = 8'h00;
    m_len   = 1;
    m_tgt   = 0;
    m_ovl   = 1'b1;
    m_cnt   = 0;
    m_hist.delete();
    m_ypend = 1'b0;
  endtask

  // Does the newest bit complete the pattern over the last m_len bits?
  function automatic bit model_mealy(bit xx, bit xv);
    bit b;
    if (m_mode != 1 || !xv) return 1'b0;
    if (m_hist.size() < m_len - 1) return 1'b0;
    for (int k = 0; k < m_len; k++) begin
      b = (k == 0) ? xx : m_hist[m_hist.size() - k];
      if (b != m_pat[k]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic rec_clear();
    ymask = 16'h0000;
    dmask = 16'h0000;
    tidx  = 0;
  endtask

  task automatic tick(input bit r, input bit cv, input logic [7:0] cp, input logic [3:0] cl,
                      input logic [7:0] ct, input bit co, input bit st, input bit ab,
                      input bit xx, input bit xv);
    bit ym;
    bit ye;
    rst             = r;
    bus.cfg_valid   = cv;
    bus.cfg_pattern = cp;
    bus.cfg_len     = cl;
    bus.cfg_target  = ct;
    bus.cfg_overlap = co;
    bus.start       = st;
    bus.abort       = ab;
    bus.x           = xx;
    bus.x_valid     = xv;
    @(negedge clk);
    ym = model_mealy(xx, xv);
`ifdef SEQ_DET_MOORE_OUT_EN
    ye = m_ypend;
`else
    ye = ym;
`endif
    chk("y",         32'(bus.y),         32'(ye));
    chk("match_cnt", 32'(bus.match_cnt), 32'(m_cnt));
    chk("busy",      32'(bus.busy),      32'(m_mode == 1));
    chk("done",      32'(bus.done),      32'(m_mode == 2));
    chk("cfg_ready", 32'(bus.cfg_ready), 32'(m_mode == 0));
    if (tidx < 16) begin
      ymask[tidx] = bus.y;
      dmask[tidx] = bus.done;
      tidx++;
    end
    if (r) begin
      model_reset();
    end else begin
      m_ypend = ym;
      case (m_mode)
        0: begin
          if (cv) begin
            m_pat = cp;
            m_len = (cl == 4'd0) ? 1 : ((cl > 4'd8) ? 8 : int'(cl));
            m_tgt = int'(ct);
            m_ovl = co;
          end
          if (st) begin
            m_mode = 1;
            m_cnt  = 0;
            m_hist.delete();
          end
        end
        1: begin
          if (xv) begin
            m_hist.push_back(xx);
            if (m_hist.size() > PAT_W) void'(m_hist.pop_front());
          end
          if (ym) begin
            if (m_cnt < 255) m_cnt++;
            if (!m_ovl) m_hist.delete();
          end
          if (ab) m_mode = 0;
          else if (ym && m_tgt != 0 && m_cnt == m_tgt) m_mode = 2;
        end
        default: m_mode = 0;
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  task automatic t_idle();
    tick(1'b0, 1'b0, 8'h00, 4'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic t_arm(input logic [7:0] p, input logic [3:0] l, input logic [7:0] t, input bit o);
    tick(1'b0, 1'b1, p, l, t, o, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic t_bit(input bit xx, input bit xv);
    tick(1'b0, 1'b0, 8'h00, 4'd0, 8'd0, 1'b0, 1'b0, 1'b0, xx, xv);
  endtask

  task automatic t_abort(input bit xx, input bit xv);
    tick(1'b0, 1'b0, 8'h00, 4'd0, 8'd0, 1'b0, 1'b0, 1'b1, xx, xv);
  endtask

  bit s1[8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  bit s3[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    rst             = 1'b1;
    bus.cfg_valid   = 1'b0;
    bus.cfg_pattern = 8'h00;
    bus.cfg_len     = 4'd0;
    bus.cfg_target  = 8'd0;
    bus.cfg_overlap = 1'b0;
    bus.start       = 1'b0;
    bus.abort       = 1'b0;
    bus.x           = 1'b0;
    bus.x_valid     = 1'b0;
    rec_clear();
    model_reset();
    repeat (3) @(posedge clk);
    #1;

    // Reset state.
    tick(1'b1, 1'b0, 8'h00, 4'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_cfg_ready", 32'(bus.cfg_ready), 32'd1);
    chk("rst_cnt",       32'(bus.match_cnt), 32'd0);
    chk("rst_y",         32'(bus.y),         32'd0);

    // Pattern 11, overlapping, free-run.
    t_arm(8'h03, 4'd2, 8'd0, 1'b1);
    rec_clear();
    for (int i = 0; i < 8; i++) t_bit(s1[i], 1'b1);
`ifdef SEQ_DET_MOORE_OUT_EN
    chk("t1_y_pos", 32'(ymask), 32'h00E0);
`else
    chk("t1_y_pos", 32'(ymask), 32'h0070);
`endif
    chk("t1_cnt",  32'(bus.match_cnt), 32'd3);
    chk("t1_done", 32'(dmask),         32'd0);
    t_abort(1'b0, 1'b0);

    // Same stream, non-overlapping.
    t_arm(8'h03, 4'd2, 8'd0, 1'b0);
    rec_clear();
    for (int i = 0; i < 8; i++) t_bit(s1[i], 1'b1);
`ifdef SEQ_DET_MOORE_OUT_EN
    chk("t2_y_pos", 32'(ymask), 32'h00A0);
`else
    chk("t2_y_pos", 32'(ymask), 32'h0050);
`endif
    chk("t2_cnt", 32'(bus.match_cnt), 32'd2);
    t_abort(1'b0, 1'b0);

    // Pattern 101, target 2: completes into DONE then IDLE.
    t_arm(8'h05, 4'd3, 8'd2, 1'b1);
    rec_clear();
    for (int i = 0; i < 5; i++) t_bit(s3[i], 1'b1);
    t_idle();
    t_idle();
`ifdef SEQ_DET_MOORE_OUT_EN
    chk("t3_y_pos", 32'(ymask), 32'h0028);
`else
    chk("t3_y_pos", 32'(ymask), 32'h0014);
`endif
    chk("t3_done_pos",  32'(dmask),         32'h0020);
    chk("t3_cnt",       32'(bus.match_cnt), 32'd2);
    chk("t3_cfg_ready", 32'(bus.cfg_ready), 32'd1);

    // Abort coinciding with a match.
    t_arm(8'h01, 4'd1, 8'd0, 1'b1);
    rec_clear();
    t_bit(1'b1, 1'b1);
    t_abort(1'b1, 1'b1);
    chk("t4_cnt",  32'(bus.match_cnt), 32'd2);
    chk("t4_busy", 32'(bus.busy),      32'd0);
    t_idle();
`ifdef SEQ_DET_MOORE_OUT_EN
    chk("t4_y_pos", 32'(ymask), 32'h0006);
`else
    chk("t4_y_pos", 32'(ymask), 32'h0003);
`endif
    chk("t4_done", 32'(dmask), 32'd0);

    // Length 0 behaves as length 1.
    t_arm(8'h01, 4'd0, 8'd0, 1'b1);
    rec_clear();
    t_bit(1'b1, 1'b1);
    t_bit(1'b0, 1'b1);
    t_bit(1'b1, 1'b1);
    t_bit(1'b1, 1'b1);
    t_bit(1'b0, 1'b0);
`ifdef SEQ_DET_MOORE_OUT_EN
    chk("t5a_y_pos", 32'(ymask), 32'h001A);
`else
    chk("t5a_y_pos", 32'(ymask), 32'h000D);
`endif
    t_abort(1'b0, 1'b0);

    // Length 15 clamps to 8: first match needs 7 bits of prior history.
    t_arm(8'hFF, 4'd15, 8'd0, 1'b1);
    rec_clear();
    for (int i = 0; i < 9; i++) t_bit(1'b1, 1'b1);
    t_bit(1'b0, 1'b0);
`ifdef SEQ_DET_MOORE_OUT_EN
    chk("t5b_y_pos", 32'(ymask), 32'h0300);
`else
    chk("t5b_y_pos", 32'(ymask), 32'h0180);
`endif
    chk("t5b_cnt", 32'(bus.match_cnt), 32'd2);
    t_abort(1'b0, 1'b0);

    // Reset while armed.
    t_arm(8'h01, 4'd1, 8'd0, 1'b1);
    for (int i = 0; i < 3; i++) t_bit(1'b1, 1'b1);
    chk("t6_cnt_pre", 32'(bus.match_cnt), 32'd3);
    tick(1'b1, 1'b0, 8'h00, 4'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t6_cnt",       32'(bus.match_cnt), 32'd0);
    chk("t6_busy",      32'(bus.busy),      32'd0);
    chk("t6_cfg_ready", 32'(bus.cfg_ready), 32'd1);
    chk("t6_y",         32'(bus.y),         32'd0);

    // Randomized traffic against the model.
    for (int n = 0; n < 2500; n++) begin
      tick(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 3) == 0),
           8'($urandom),
           ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3)),
           8'($urandom_range(0, 4)),
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 63) == 0),
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 4) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
